register_bank_8x16: RTL and testbench



---
 rtl/register_bank_8x16_if.sv | 26 ++
 rtl/register_bank_8x16.sv | 40 ++++
 tb/tb_register_bank_8x16.sv | 123 ++++++++++++
 3 files changed

// File: rtl/register_bank_8x16_if.sv
// Register-bank access bus: write data, shared read/write index, per-register write
// enables, and the combinational read data coming back.
interface register_bank_8x16_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  out;
    logic [ADDR_W-1:0] reg_num;
    logic [DEPTH-1:0]  enable;

    modport master (
        output in,
        output reg_num,
        output enable,
        input  out
    );

    modport slave (
        input  in,
        input  reg_num,
        input  enable,
        output out
    );
endinterface

// File: rtl/register_bank_8x16.sv
// Eight-entry general-purpose register file: synchronous enable-qualified writes and a
// combinational read of the register selected by reg_num.
module register_bank_8x16 #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    register_bank_8x16_if.slave bus
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    // Only enable[reg_num] matters; an unknown index never matches, so nothing is written.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (bus.enable[i] && (bus.reg_num == ADDR_W'(i))) begin
                regs_d[i] = bus.in;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign bus.out = regs_q[bus.reg_num];

endmodule

// File: tb/tb_register_bank_8x16.sv
// Scoreboarded bench for register_bank_8x16: a reference array predicts every read,
// expectations are queued when stimulus is driven and compared when out settles.
module tb_register_bank_8x16;

    logic clk;
    logic rst_n;

    register_bank_8x16_if #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) bus ();

    register_bank_8x16 #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] model [8];
    logic        model_valid;
    logic [15:0] exp_q [$];
    int          n_tests;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, act, exp);
        end
    endtask

    // One clock cycle of stimulus; also checks the pre-edge (old) value on out.
    task automatic step(input logic rst, input logic [2:0] rn, input logic [7:0] en,
                        input logic [15:0] d, input string tag);
        @(negedge clk);
        rst_n       = rst;
        bus.reg_num = rn;
        bus.enable  = en;
        bus.in      = d;
        #1;
        if (model_valid) check_eq({tag, "_pre"}, bus.out, model[rn]);
        if (!rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
            model_valid = 1'b1;
        end else if (en[rn]) begin
            model[rn] = d;
        end
        exp_q.push_back(model[rn]);
        @(posedge clk);
        #1;
        check_eq(tag, bus.out, exp_q.pop_front());
    endtask

    // Combinational read: no clock edge between select and compare.
    task automatic read(input logic [2:0] rn, input string tag);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.reg_num = rn;
        bus.enable  = 8'h00;
        exp_q.push_back(model[rn]);
        #1;
        check_eq(tag, bus.out, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        model_valid = 1'b0;
        rst_n       = 1'b0;
        bus.reg_num = 3'd0;
        bus.enable  = 8'h00;
        bus.in      = 16'h0000;

        step(1'b0, 3'd0, 8'h00, 16'h0000, "rst0");
        step(1'b0, 3'd0, 8'h00, 16'h0000, "rst1");
        for (int i = 0; i < 8; i++) read(3'(i), $sformatf("rst_rd%0d", i));

        step(1'b1, 3'd0, 8'b0000_0001, 16'd256, "wr_r0");
        read(3'd1, "rd_r1_zero");

        step(1'b1, 3'd4, 8'b0001_0001, 16'd35, "multi_en_r4");
        read(3'd0, "r0_kept");

        step(1'b1, 3'd5, 8'b0001_0001, 16'd22, "gated_r5");
        read(3'd5, "r5_still0");

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 8'(1 << i), 16'(i * 16'h1111), $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 8; i++) read(3'(i), $sformatf("fill_rd%0d", i));

        step(1'b1, 3'd7, 8'h80, 16'h1234, "rdw_r7_a");
        step(1'b1, 3'd7, 8'h80, 16'h5678, "rdw_r7_b");

        for (int k = 0; k < 40; k++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom),
                 $sformatf("rand%0d", k));
            if (k % 5 == 4) read(3'($urandom_range(0, 7)), $sformatf("rand_rd%0d", k));
        end

        step(1'b0, 3'd3, 8'hFF, 16'hBEEF, "rst_prio");
        for (int i = 0; i < 8; i++) read(3'(i), $sformatf("prio_rd%0d", i));
        step(1'b1, 3'd3, 8'hFF, 16'hBEEF, "post_rst_wr");
        read(3'd2, "post_rst_r2");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
